// File: rtl/response_sm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// response_sm_pkg : shared constants and state encoding for response_sm
// Revision 1.0
// ---------------------------------------------------------------------------
package response_sm_pkg;

  localparam int WORD_W = 32;
  localparam int KEEP_W = WORD_W / 8;
  localparam logic [KEEP_W-1:0] TKEEP_ALL = 4'hF;

  localparam int IDX_IDLE      = 0;
  localparam int IDX_HDR_RC    = 1;
  localparam int IDX_HDR_RDC   = 2;
  localparam int IDX_DATA      = 3;
  localparam int IDX_WAIT_LAST = 4;
  localparam int IDX_DONE      = 5;
  localparam int NUM_STATES    = 6;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE      = 6'(1 << IDX_IDLE),
    S_HDR_RC    = 6'(1 << IDX_HDR_RC),
    S_HDR_RDC   = 6'(1 << IDX_HDR_RDC),
    S_DATA      = 6'(1 << IDX_DATA),
    S_WAIT_LAST = 6'(1 << IDX_WAIT_LAST),
    S_DONE      = 6'(1 << IDX_DONE)
  } state_e;

  localparam logic [WORD_W-1:0] RC_OK      = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RC_ILLEGAL = 32'h0000_0101;

endpackage
`default_nettype wire

// File: rtl/response_sm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// response_sm_if : requester, read-data and tx stream signals of response_sm
// Revision 1.0
// ---------------------------------------------------------------------------
interface response_sm_if #(
  parameter int CNT_W = 8
);
  import response_sm_pkg::*;

  logic [WORD_W-1:0] ser_num;
  logic              rsp_req;
  logic [WORD_W-1:0] rsp_code;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              rsp_ack;
  logic              rsp_busy;
  logic              rsp_done;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] tx_tdata;
  logic              tx_tvalid;
  logic [KEEP_W-1:0] tx_tkeep;
  logic              tx_tlast;
  logic              tx_tready;

  modport master (
    output ser_num, rsp_req, rsp_code, rsp_cnt, rd_data, rd_valid, tx_tready,
    input  rsp_ack, rsp_busy, rsp_done, rd_ready,
    input  tx_tdata, tx_tvalid, tx_tkeep, tx_tlast
  );

  modport slave (
    input  ser_num, rsp_req, rsp_code, rsp_cnt, rd_data, rd_valid, tx_tready,
    output rsp_ack, rsp_busy, rsp_done, rd_ready,
    output tx_tdata, tx_tvalid, tx_tkeep, tx_tlast
  );

endinterface
`default_nettype wire

// File: rtl/response_sm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// response_sm : frames RSN, RC, RDC, RD1..RDn onto a registered 32-bit stream
// Revision 1.0
// ---------------------------------------------------------------------------
module response_sm
  import response_sm_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  response_sm_if.slave  bus
);

  state_e state_q, state_d;

  logic [WORD_W-1:0] rc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic [KEEP_W-1:0] tkeep_q;
  logic              ack_q;
  logic              busy_q;
  logic              done_q;

  logic can_load;
  logic tx_hs;
  logic rd_ready;
  logic rd_hs;

  // The single output register may take a new word when empty or draining.
  assign can_load = !tvalid_q || bus.tx_tready;
  assign tx_hs    = tvalid_q && bus.tx_tready;
  assign rd_ready = (state_q == S_DATA) && can_load;
  assign rd_hs    = rd_ready && bus.rd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.rsp_req) state_d = S_HDR_RC;
      S_HDR_RC:    if (can_load) state_d = S_HDR_RDC;
      S_HDR_RDC:   if (can_load) state_d = (cnt_q == '0) ? S_WAIT_LAST : S_DATA;
      S_DATA:      if (rd_hs && (cnt_q == CNT_W'(1))) state_d = S_WAIT_LAST;
      S_WAIT_LAST: if (tx_hs && tlast_q) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q     <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      // Drain first; any load below in the same cycle takes precedence.
      if (tx_hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tkeep_q  <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.rsp_req) begin
            rc_q     <= bus.rsp_code;
            cnt_q    <= bus.rsp_cnt;
            tdata_q  <= bus.ser_num;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tkeep_q  <= TKEEP_ALL;
            ack_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_HDR_RC: begin
          if (can_load) begin
            tdata_q  <= rc_q;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tkeep_q  <= TKEEP_ALL;
          end
        end
        S_HDR_RDC: begin
          if (can_load) begin
            tdata_q  <= DATA_W'(cnt_q);
            tvalid_q <= 1'b1;
            tlast_q  <= (cnt_q == '0);
            tkeep_q  <= TKEEP_ALL;
          end
        end
        S_DATA: begin
          if (rd_hs) begin
            tdata_q  <= bus.rd_data;
            tvalid_q <= 1'b1;
            tlast_q  <= (cnt_q == CNT_W'(1));
            tkeep_q  <= TKEEP_ALL;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        S_WAIT_LAST: begin
          if (tx_hs && tlast_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_ack   = ack_q;
  assign bus.rsp_busy  = busy_q;
  assign bus.rsp_done  = done_q;
  assign bus.rd_ready  = rd_ready;
  assign bus.tx_tdata  = tdata_q;
  assign bus.tx_tvalid = tvalid_q;
  assign bus.tx_tlast  = tlast_q;
  assign bus.tx_tkeep  = tkeep_q;

endmodule
`default_nettype wire

// File: tb/tb_response_sm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_response_sm : directed self-checking bench for response_sm
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_response_sm;
  import response_sm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  response_sm_if #(.CNT_W(8)) bus();

  response_sm #(.CNT_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream {tlast, tdata} and requester data, both appended by the main process.
  logic [32:0] exp_q[$];
  logic [31:0] rd_q[$];
  int  epoch;
  int  rd_gap;
  bit  bp_en;

  // Written only by the monitor.
  bit  rd_took;
  int  ack_cnt, done_cnt, ack_cyc, done_cyc, rd_hs, vld_cnt, exp_ptr;
  int  cyc;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requester data source and downstream ready.
  initial begin
    int rd_ptr, gap_cnt, seen_ep;
    rd_ptr = 0; gap_cnt = 0; seen_ep = 0;
    bus.rd_valid = 1'b0; bus.rd_data = '0; bus.tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (seen_ep != epoch) begin
        seen_ep = epoch;
        rd_ptr  = rd_q.size();
        gap_cnt = 0;
      end else if (rd_took) begin
        rd_ptr++;
        gap_cnt = rd_gap;
      end
      if (gap_cnt > 0) begin
        bus.rd_valid = 1'b0;
        gap_cnt--;
      end else if (rd_ptr < rd_q.size()) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = rd_q[rd_ptr];
      end else begin
        bus.rd_valid = 1'b0;
      end
      bus.tx_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Stream monitor, sampled on the falling edge.
  initial begin
    int pkt_idx, seen_ep;
    bit stall_prev, exp_done;
    logic [31:0] prev_data;
    logic        prev_last;
    pkt_idx = 0; seen_ep = 0; stall_prev = 0; exp_done = 0;
    prev_data = '0; prev_last = 1'b0; rd_took = 0;
    ack_cnt = 0; done_cnt = 0; ack_cyc = 0; done_cyc = 0; rd_hs = 0; vld_cnt = 0; exp_ptr = 0;
    forever begin
      @(negedge clk);
      if (seen_ep != epoch) begin
        seen_ep = epoch;
        exp_ptr = exp_q.size();
      end
      if (reset) begin
        stall_prev = 0; exp_done = 0; rd_took = 0;
      end else begin
        if (bus.rsp_ack) begin
          ack_cnt++; ack_cyc = cyc; pkt_idx = 0; vld_cnt = 0;
        end
        if (bus.rsp_done) begin
          done_cnt++; done_cyc = cyc;
        end
        if (bus.rsp_done || exp_done) check("rsp_done_timing", bus.rsp_done, exp_done);
        exp_done = 0;
        if (!bus.rsp_busy || pkt_idx < 2) check("rd_ready_outside_data", bus.rd_ready, 0);
        rd_took = bus.rd_valid && bus.rd_ready;
        if (rd_took) rd_hs++;
        if (stall_prev) begin
          check("stall_tvalid", bus.tx_tvalid, 1);
          check("stall_tdata", bus.tx_tdata, prev_data);
          check("stall_tlast", bus.tx_tlast, prev_last);
        end
        if (bus.tx_tvalid) begin
          vld_cnt++;
          check("tkeep", bus.tx_tkeep, 4'hF);
        end
        if (bus.tx_tvalid && bus.tx_tready) begin
          if (exp_ptr < exp_q.size()) begin
            check("tdata", bus.tx_tdata, exp_q[exp_ptr][31:0]);
            check("tlast", bus.tx_tlast, exp_q[exp_ptr][32]);
            exp_ptr++;
          end else begin
            check("unexpected_word", bus.tx_tvalid, 0);
          end
          if (bus.tx_tlast) exp_done = 1;
          pkt_idx++;
        end
        stall_prev = bus.tx_tvalid && !bus.tx_tready;
        prev_data  = bus.tx_tdata;
        prev_last  = bus.tx_tlast;
      end
    end
  end

  task automatic push_pkt(input logic [31:0] sn, input logic [31:0] rc, input int n,
                          input logic [31:0] base);
    exp_q.push_back({1'b0, sn});
    exp_q.push_back({1'b0, rc});
    exp_q.push_back({(n == 0), 32'(n)});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), base + 32'(i)});
      rd_q.push_back(base + 32'(i));
    end
  endtask

  task automatic request(input logic [31:0] sn, input logic [31:0] rc, input int n);
    int k;
    @(posedge clk);
    #1;
    bus.ser_num  = sn;
    bus.rsp_code = rc;
    bus.rsp_cnt  = 8'(n);
    bus.rsp_req  = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_ack && k < 20);
    check("ack_seen", bus.rsp_ack, 1);
    @(posedge clk);
    #1;
    bus.rsp_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cnt, target);
  endtask

  task automatic run_pkt(input logic [31:0] sn, input logic [31:0] rc, input int n,
                         input logic [31:0] base, input int exp_lat, input string name);
    int a0, d0, r0;
    a0 = ack_cnt; d0 = done_cnt; r0 = rd_hs;
    push_pkt(sn, rc, n, base);
    request(sn, rc, n);
    wait_done(d0 + 1);
    check({name, "_acks"}, ack_cnt - a0, 1);
    check({name, "_rd_handshakes"}, rd_hs - r0, n);
    check({name, "_words_left"}, exp_ptr, exp_q.size());
    if (exp_lat >= 0) check({name, "_latency"}, done_cyc - ack_cyc, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    int a0, d0, r0, k, a_done;
    reset = 1'b0;
    epoch = 0; rd_gap = 0; bp_en = 0;
    bus.rsp_req = 1'b0; bus.ser_num = '0; bus.rsp_code = '0; bus.rsp_cnt = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tvalid", bus.tx_tvalid, 0);
    check("rst_tlast", bus.tx_tlast, 0);
    check("rst_tdata", bus.tx_tdata, 0);
    check("rst_tkeep", bus.tx_tkeep, 0);
    check("rst_ack", bus.rsp_ack, 0);
    check("rst_busy", bus.rsp_busy, 0);
    check("rst_done", bus.rsp_done, 0);
    check("rst_rd_ready", bus.rd_ready, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Empty packet and back-to-back data packet.
    run_pkt(32'h12, RC_ILLEGAL, 0, 32'h0, 3, "t1");
    run_pkt(32'h13, RC_OK, 3, 32'hA, 6, "t2");

    // Random backpressure.
    bp_en = 1;
    run_pkt(32'h14, 32'h33, 3, 32'hA, -1, "t3");
    bp_en = 0;

    // Two idle cycles between requester words.
    rd_gap = 2;
    run_pkt(32'h15, 32'h44, 4, 32'h1, 13, "t4");
    check("t4_valid_cycles", vld_cnt, 7);
    rd_gap = 0;

    // Second request raised while the first packet is in flight.
    a0 = ack_cnt; d0 = done_cnt; r0 = rd_hs;
    push_pkt(32'h21, 32'h55, 2, 32'h1);
    push_pkt(32'h31, RC_ILLEGAL, 1, 32'h9);
    request(32'h21, 32'h55, 2);
    @(posedge clk);
    #1;
    bus.ser_num  = 32'h31;
    bus.rsp_code = RC_ILLEGAL;
    bus.rsp_cnt  = 8'd1;
    bus.rsp_req  = 1'b1;
    wait_done(d0 + 1);
    a_done = done_cyc;
    check("t5_ack_during_busy", ack_cnt - a0, 1);
    k = 0;
    while (ack_cnt < a0 + 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_second_ack", ack_cnt - a0, 2);
    check("t5_ack_gap", ack_cyc - a_done, 2);
    @(posedge clk);
    #1;
    bus.rsp_req = 1'b0;
    wait_done(d0 + 2);
    check("t5_total_acks", ack_cnt - a0, 2);
    check("t5_rd_handshakes", rd_hs - r0, 3);
    check("t5_words_left", exp_ptr, exp_q.size());
    @(negedge clk);

    // Asynchronous reset after the first data word.
    r0 = rd_hs;
    push_pkt(32'h41, 32'h66, 3, 32'h5);
    request(32'h41, 32'h66, 3);
    k = 0;
    while (rd_hs == r0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t6_first_rd", rd_hs - r0, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_tvalid", bus.tx_tvalid, 0);
    check("t6_tlast", bus.tx_tlast, 0);
    check("t6_tdata", bus.tx_tdata, 0);
    check("t6_tkeep", bus.tx_tkeep, 0);
    check("t6_ack", bus.rsp_ack, 0);
    check("t6_busy", bus.rsp_busy, 0);
    check("t6_done", bus.rsp_done, 0);
    check("t6_rd_ready", bus.rd_ready, 0);
    epoch = epoch + 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_pkt(32'h61, 32'h606, 1, 32'h77, 4, "t6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
